// File: rtl/sal_cmd_arb.sv
`default_nettype none
// ============================================================================
// Module   : sal_cmd_arb
// Purpose  : Single-slot DFI command arbiter shared by NUM_BK bank
//            controllers. Class priority REF > PRE > CAS > ACT, round-robin
//            inside a class, with tRRD / tCCD / tWTR spacing counters.
//            Grants are combinational from requests and registered state.
// Options  : `define SAL_CMD_ARB_STARVE_EN adds per-bank 8-bit wait counters;
//            a bank whose counter reaches STARVE_LIMIT and has an eligible
//            request wins over class priority and the round-robin pointer.
// Revision : 1.0  initial release
// ============================================================================
module sal_cmd_arb #(
  parameter int NUM_BK       = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_BK-1:0] act_req_i,
  input  logic [NUM_BK-1:0] cas_req_i,
  input  logic [NUM_BK-1:0] cas_wr_i,
  input  logic [NUM_BK-1:0] pre_req_i,
  input  logic [NUM_BK-1:0] ref_req_i,
  input  logic [3:0]        t_rrd_i,
  input  logic [2:0]        t_ccd_i,
  input  logic [3:0]        t_wtr_i,
  output logic [NUM_BK-1:0] gnt_o,
  output logic [2:0]        gnt_cmd_o,
  output logic              gnt_valid_o
);

  localparam int PTR_W = (NUM_BK > 1) ? $clog2(NUM_BK) : 1;

  localparam logic [2:0] c_CMD_NOP = 3'd0;
  localparam logic [2:0] c_CMD_ACT = 3'd1;
  localparam logic [2:0] c_CMD_RD  = 3'd2;
  localparam logic [2:0] c_CMD_WR  = 3'd3;
  localparam logic [2:0] c_CMD_PRE = 3'd4;
  localparam logic [2:0] c_CMD_REF = 3'd5;

  // Elaboration-time range guard on the configuration parameters
  if (NUM_BK < 2 || NUM_BK > 8 || STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_param
    $error("sal_cmd_arb: NUM_BK must be 2..8 and STARVE_LIMIT 1..255");
  end

  logic [PTR_W-1:0] r_rr_ptr;
  logic [3:0]       r_rrd_cnt;
  logic [2:0]       r_ccd_cnt;
  logic [3:0]       r_wtr_cnt;

  logic [NUM_BK-1:0] w_act_el;
  logic [NUM_BK-1:0] w_cas_el;
  logic [NUM_BK-1:0] w_pre_el;
  logic [NUM_BK-1:0] w_ref_el;
  logic [NUM_BK-1:0] w_any_el;
  logic [NUM_BK-1:0] w_any_req;
  logic [NUM_BK-1:0] w_cls_mask;
  logic [2:0]        w_bank_cmd [NUM_BK];
  logic              w_found;
  logic [PTR_W-1:0]  w_sel;
  logic [PTR_W:0]    w_idx;
  logic [PTR_W-1:0]  w_ptr_nxt;

  // REF and PRE have no spacing constraint; ACT waits on tRRD as a whole
  assign w_ref_el  = ref_req_i;
  assign w_pre_el  = pre_req_i;
  assign w_act_el  = (r_rrd_cnt == 4'd0) ? act_req_i : '0;
  assign w_any_el  = w_ref_el | w_pre_el | w_cas_el | w_act_el;
  assign w_any_req = act_req_i | cas_req_i | pre_req_i | ref_req_i;

  // Per-bank CAS eligibility (RD also needs tWTR clear) and the command the
  // bank would issue: its highest eligible class. The bank picked inside the
  // globally highest class necessarily has that class as its own highest.
  for (genvar b = 0; b < NUM_BK; b++) begin : g_bank
    assign w_cas_el[b] = cas_req_i[b] && (r_ccd_cnt == 3'd0) &&
                         (cas_wr_i[b] || (r_wtr_cnt == 4'd0));
    assign w_bank_cmd[b] = w_ref_el[b] ? c_CMD_REF :
                           w_pre_el[b] ? c_CMD_PRE :
                           w_cas_el[b] ? (cas_wr_i[b] ? c_CMD_WR : c_CMD_RD) :
                           w_act_el[b] ? c_CMD_ACT : c_CMD_NOP;
  end : g_bank

`ifdef SAL_CMD_ARB_STARVE_EN
  logic [7:0] r_wait [NUM_BK];

  // Per-bank wait counters: count unserved cycles, clear on grant or idle
  for (genvar b = 0; b < NUM_BK; b++) begin : g_wait
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_wait[b] <= 8'd0;
      end else if (!w_any_req[b] || gnt_o[b]) begin
        r_wait[b] <= 8'd0;
      end else if (r_wait[b] != 8'(STARVE_LIMIT)) begin
        r_wait[b] <= r_wait[b] + 8'd1;
      end
    end
  end : g_wait
`endif

  // Pick the highest class that holds at least one eligible request
  always_comb begin
    w_cls_mask = '0;
    if (|w_ref_el)      w_cls_mask = w_ref_el;
    else if (|w_pre_el) w_cls_mask = w_pre_el;
    else if (|w_cas_el) w_cls_mask = w_cas_el;
    else                w_cls_mask = w_act_el;
  end

  // Round-robin search from r_rr_ptr upward with wrap, then starvation override
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_BK; i++) begin
      w_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(i);
      if (w_idx >= (PTR_W+1)'(NUM_BK)) begin
        w_idx = w_idx - (PTR_W+1)'(NUM_BK);
      end
      if (!w_found && w_cls_mask[w_idx[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[PTR_W-1:0];
      end
    end
`ifdef SAL_CMD_ARB_STARVE_EN
    // Descending scan so the lowest-index starving bank is the last to win
    for (int b = NUM_BK - 1; b >= 0; b--) begin
      if ((r_wait[b] == 8'(STARVE_LIMIT)) && w_any_el[b]) begin
        w_found = 1'b1;
        w_sel   = PTR_W'(b);
      end
    end
`endif
  end

  // Outputs are forced idle while reset is asserted
  assign gnt_valid_o = rst_n && w_found;
  assign gnt_o       = gnt_valid_o ? (NUM_BK'(1) << w_sel) : '0;
  assign gnt_cmd_o   = gnt_valid_o ? w_bank_cmd[w_sel] : c_CMD_NOP;
  assign w_ptr_nxt   = (w_sel == PTR_W'(NUM_BK - 1)) ? '0 : w_sel + 1'b1;

  // Pointer advance and spacing counters: load (t-1, floor 0) on grant, else count down
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr  <= '0;
      r_rrd_cnt <= 4'd0;
      r_ccd_cnt <= 3'd0;
      r_wtr_cnt <= 4'd0;
    end else begin
      if (gnt_valid_o) begin
        r_rr_ptr <= w_ptr_nxt;
      end

      if (gnt_valid_o && (gnt_cmd_o == c_CMD_ACT)) begin
        r_rrd_cnt <= (t_rrd_i == 4'd0) ? 4'd0 : t_rrd_i - 4'd1;
      end else if (r_rrd_cnt != 4'd0) begin
        r_rrd_cnt <= r_rrd_cnt - 4'd1;
      end

      if (gnt_valid_o && ((gnt_cmd_o == c_CMD_RD) || (gnt_cmd_o == c_CMD_WR))) begin
        r_ccd_cnt <= (t_ccd_i == 3'd0) ? 3'd0 : t_ccd_i - 3'd1;
      end else if (r_ccd_cnt != 3'd0) begin
        r_ccd_cnt <= r_ccd_cnt - 3'd1;
      end

      if (gnt_valid_o && (gnt_cmd_o == c_CMD_WR)) begin
        r_wtr_cnt <= (t_wtr_i == 4'd0) ? 4'd0 : t_wtr_i - 4'd1;
      end else if (r_wtr_cnt != 4'd0) begin
        r_wtr_cnt <= r_wtr_cnt - 4'd1;
      end
    end
  end

endmodule : sal_cmd_arb
`default_nettype wire

// File: doc/sal_cmd_arb.md
SAL_CMD_ARB -- requirements
Module: sal_cmd_arb

Interface
REQ-001 Parameter NUM_BK, default 4, number of bank controllers sharing the DFI command slot (2..8).
REQ-002 Parameter STARVE_LIMIT, default 15, wait-cycle threshold for starvation override (1..255).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 act_req_i  input  NUM_BK  per-bank ACTIVATE request.
REQ-006 cas_req_i  input  NUM_BK  per-bank column (RD/WR) request.
REQ-007 cas_wr_i  input  NUM_BK  per-bank CAS type: 1=WR, 0=RD; meaningful only with cas_req_i.
REQ-008 pre_req_i  input  NUM_BK  per-bank PRECHARGE request.
REQ-009 ref_req_i  input  NUM_BK  per-bank AUTO-REFRESH request.
REQ-010 t_rrd_i  input  4  ACT-to-ACT spacing, cycles.
REQ-011 t_ccd_i  input  3  CAS-to-CAS spacing, cycles.
REQ-012 t_wtr_i  input  4  WR-to-RD turnaround, cycles.
REQ-013 gnt_o  output  NUM_BK  one-hot grant; zero when nothing granted.
REQ-014 gnt_cmd_o  output  3  granted command: 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF.
REQ-015 gnt_valid_o  output  1  high when gnt_o is non-zero.

Function
REQ-016 Grant outputs SHALL be combinational from current requests and registered state (zero-cycle latency); at most one bank, one command per cycle.
REQ-017 Class priority SHALL be REF > PRE > CAS > ACT; a bank asserting several requests is considered in each class it asserts.
REQ-018 Within the highest class having an eligible request, the grant SHALL go to the first requesting bank found searching upward from rr_ptr, wrapping NUM_BK-1 -> 0.
REQ-019 After any grant to bank k, rr_ptr SHALL become (k+1) mod NUM_BK; with no grant rr_ptr SHALL hold.
REQ-020 ACT SHALL be eligible only when rrd counter is 0; ACT granted at cycle n -> next ACT no earlier than n+max(t_rrd_i,1).
REQ-021 CAS SHALL be eligible only when ccd counter is 0; CAS at cycle n -> next CAS no earlier than n+max(t_ccd_i,1).
REQ-022 RD SHALL additionally require wtr counter 0; WR granted at cycle n -> next RD no earlier than n+max(t_wtr_i,1); WR after RD unrestricted beyond tCCD.
REQ-023 Each counter SHALL load (value-1, floored at 0) on its triggering grant, decrement by 1 per cycle, saturate at 0.
REQ-024 Ineligible requests SHALL NOT block lower classes: if only a timing-blocked CAS and an eligible ACT exist, ACT is granted.
REQ-025 Timing inputs SHALL be sampled only at load time; changes mid-count do not affect running counters.
REQ-026 When no eligible request exists, outputs SHALL be gnt_o=0, gnt_cmd_o=0, gnt_valid_o=0.

Reset
REQ-027 While rst_n low at a clock edge: rr_ptr=0, rrd/ccd/wtr counters=0, starvation counters=0.
REQ-028 While rst_n is low, gnt_o=0, gnt_cmd_o=0, gnt_valid_o=0 regardless of requests; reset mid-countdown SHALL clear counters so requests are eligible the cycle after rst_n rises.

Configuration
REQ-029 Macro SAL_CMD_ARB_STARVE_EN: when defined, per-bank wait counters (8 bits) SHALL increment each cycle the bank has any request and is not granted, clear on grant or when it has no request, saturate at STARVE_LIMIT.
REQ-030 With SAL_CMD_ARB_STARVE_EN defined, the lowest-index bank whose counter equals STARVE_LIMIT and which has an eligible request SHALL win, regardless of class and rr_ptr, using its highest-priority eligible class.
REQ-031 Without SAL_CMD_ARB_STARVE_EN, no wait counters SHALL exist and arbitration is class priority plus round-robin only.

Verification
REQ-032 Banks 0-3 all assert cas_req_i (RD), t_ccd_i=1, continuously -> grants 0,1,2,3,0 on consecutive cycles, gnt_cmd_o=2.
REQ-033 Bank 1 ACT at cycle 0 with t_rrd_i=4, bank 2 ACT asserted from cycle 1 -> bank 2 ACT granted at cycle 4, gnt_valid_o=0 cycles 1-3.
REQ-034 Bank 0 WR at cycle 0, t_wtr_i=6, t_ccd_i=2, bank 3 RD from cycle 1 -> RD granted at cycle 6.
REQ-035 Bank 2 ref_req_i and bank 0 pre_req_i plus cas_req_i same cycle -> bank 2 REF granted (gnt_cmd_o=5), next cycle bank 0 PRE.
REQ-036 STARVE_EN, STARVE_LIMIT=3, bank 3 ACT asserted while banks 0-2 continuously assert eligible CAS -> bank 3 ACT granted by 4th cycle of waiting; rst_n pulsed low mid-sequence -> outputs 0, counters cleared.
